// File: rtl/serback_pkg.sv
// Shared encodings for the serial backchannel transmitter: FSM states,
// register addresses, and status/control bit positions.
package serback_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  localparam logic [1:0] ADDR_DATA  = 2'd0;
  localparam logic [1:0] ADDR_DIVLO = 2'd1;
  localparam logic [1:0] ADDR_DIVHI = 2'd2;
  localparam logic [1:0] ADDR_CTRL  = 2'd3;

  localparam int ST_NOTFULL = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_IDLE    = 2;
  localparam int ST_OVF     = 3;

  localparam int CTRL_PAR_EN  = 0;
  localparam int CTRL_PAR_ODD = 1;
  localparam int CTRL_OVF_CLR = 7;

endpackage

// File: rtl/serback_fifo.sv
// Byte-wide synchronous FIFO, depth 2**FIFO_AW. A push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module serback_fifo #(
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata,
  output logic             full,
  output logic             empty,
  output logic [FIFO_AW:0] count
);

  localparam int DEPTH = 2 ** FIFO_AW;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // count never exceeds DEPTH, so its MSB alone marks full
  assign full  = count[FIFO_AW];
  assign empty = (count == '0);
  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/serback_fifo_tx.sv
// Buffered 8N1/8N2 UART transmitter with bus register file.
// Define SERBACK_PARITY_EN to build the optional parity bit and control bits 1:0.
module serback_fifo_tx
  import serback_pkg::*;
#(
  parameter int          FIFO_AW   = 4,
  parameter int          DIV_W     = 16,
  parameter int unsigned DIV_RESET = 434,
  parameter int          STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stb,
  input  logic       we,
  input  logic [1:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  output logic       txd,
  output logic       busy
);

  localparam int         DEPTH     = 2 ** FIFO_AW;
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  tx_state_e          state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_lat, baud_cnt;
  logic [2:0]         bit_idx;
  logic               stop_idx;
  logic [7:0]         shreg;
  logic               ovf_q, txd_q, txd_d, busy_q, tick;
  logic               wr_en, push_req, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]         fifo_rdata;
  logic [FIFO_AW:0]   fifo_count;
`ifdef SERBACK_PARITY_EN
  logic               par_en_q, par_odd_q, par_on_q, par_bit_q;
`endif

  assign wr_en    = stb && we;
  assign push_req = wr_en && (addr == ADDR_DATA);

  serback_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (fifo_pop),
    .wdata (data_in),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q     <= DIV_W'(DIV_RESET);
      ovf_q     <= 1'b0;
`ifdef SERBACK_PARITY_EN
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
`endif
    end else begin
      if (wr_en && addr == ADDR_DIVLO) div_q[7:0] <= data_in;
      if (wr_en && addr == ADDR_DIVHI) div_q <= DIV_W'({data_in, div_q[7:0]});
      if (wr_en && addr == ADDR_CTRL && data_in[CTRL_OVF_CLR]) ovf_q <= 1'b0;
      else if (push_req && fifo_full && !fifo_pop)             ovf_q <= 1'b1;
`ifdef SERBACK_PARITY_EN
      if (wr_en && addr == ADDR_CTRL) begin
        par_en_q  <= data_in[CTRL_PAR_EN];
        par_odd_q <= data_in[CTRL_PAR_ODD];
      end
`endif
    end
  end

  always_comb begin
    data_out = '0;
    case (addr)
      ADDR_DATA: begin
        data_out[ST_NOTFULL] = (fifo_count != (FIFO_AW+1)'(DEPTH));
        data_out[ST_EMPTY]   = (fifo_count == '0);
        data_out[ST_IDLE]    = fifo_empty && (state_q == S_IDLE);
        data_out[ST_OVF]     = ovf_q;
      end
      ADDR_DIVLO: data_out = div_q[7:0];
      ADDR_DIVHI: data_out = 8'(div_q >> 8);
      default: begin
`ifdef SERBACK_PARITY_EN
        data_out[CTRL_PAR_EN]  = par_en_q;
        data_out[CTRL_PAR_ODD] = par_odd_q;
`endif
      end
    endcase
  end

  assign tick = (baud_cnt == div_lat - 1'b1);

  always_comb begin
    state_d  = state_q;
    fifo_pop = 1'b0;
    txd_d    = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          state_d  = S_START;
          fifo_pop = 1'b1;
        end
      end
      S_START: begin
        txd_d = 1'b0;
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        txd_d = shreg[0];
        if (tick && bit_idx == 3'd7) begin
`ifdef SERBACK_PARITY_EN
          state_d = par_on_q ? S_PARITY : S_STOP;
`else
          state_d = S_STOP;
`endif
        end
      end
`ifdef SERBACK_PARITY_EN
      S_PARITY: begin
        txd_d = par_bit_q;
        if (tick) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick && stop_idx == STOP_LAST) begin
          // chain straight into the next frame when more bytes are queued
          if (!fifo_empty) begin
            state_d  = S_START;
            fifo_pop = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      div_lat  <= clamp_div(DIV_W'(DIV_RESET));
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
`ifdef SERBACK_PARITY_EN
      par_on_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      txd_q   <= txd_d;
      busy_q  <= !(fifo_empty && state_q == S_IDLE);
      if (fifo_pop) begin
        baud_cnt <= '0;
        bit_idx  <= '0;
        stop_idx <= 1'b0;
        div_lat  <= clamp_div(div_q);
`ifdef SERBACK_PARITY_EN
        par_on_q <= par_en_q;
`endif
      end else if (state_q != S_IDLE) begin
        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
        if (tick && state_q == S_DATA) bit_idx  <= bit_idx + 1'b1;
        if (tick && state_q == S_STOP) stop_idx <= stop_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_pop) begin
      shreg <= fifo_rdata;
`ifdef SERBACK_PARITY_EN
      par_bit_q <= (^fifo_rdata) ^ par_odd_q;
`endif
    end else if (state_q == S_DATA && tick) begin
      shreg <= shreg >> 1;
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule
